// File: rtl/l23_decap.sv
// Receive-side L2/L3 header stripper: removes a programmed header from each packet,
// optionally checks it against a header RAM, and drops/counts mismatching or runt packets.
module l23_decap #(
    parameter int DATA_W = 8,
    parameter int HDR_AW = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HDR_AW-1:0] L23dmgmt_refvalue,
    input  logic [DATA_W-1:0] L23dmgmt_data,
    input  logic [HDR_AW-1:0] L23dmgmt_writeaddr,
    input  logic              L23dmgmt_we,
    input  logic              L23dmgmt_cmpen,
    input  logic              L23dmgmt_run,
    output logic              L23dmgmt_idle,
    output logic [CNT_W-1:0]  L23dmgmt_dropcnt,
    input  logic [DATA_W-1:0] L23i_tdata,
    input  logic              L23i_tlast,
    input  logic              L23i_tuser,
    input  logic              L23i_tvalid,
    output logic              L23i_tready,
    output logic [DATA_W-1:0] L23o_tdata,
    output logic              L23o_tlast,
    output logic              L23o_tuser,
    output logic              L23o_tvalid,
    input  logic              L23o_tready
);

    localparam int HDR_DEPTH = 1 << HDR_AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PASS = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [HDR_AW-1:0]   hdr_cnt_reg, hdr_cnt_next;
    logic                mismatch_reg, mismatch_next;
    logic [DATA_W-1:0]   o_tdata_reg, o_tdata_next;
    logic                o_tlast_reg, o_tlast_next;
    logic                o_tuser_reg, o_tuser_next;
    logic                o_tvalid_reg, o_tvalid_next;
    logic [CNT_W-1:0]    dropcnt_reg, dropcnt_next;
    logic                i_tready;
    logic                accept;
    logic                drop_inc;
    logic                mis_any;
    state_t              after_pkt;

    logic [DATA_W-1:0]   hdr_ram [HDR_DEPTH];

    // Header RAM is not reset; software reloads it while the block is idle.
    always_ff @(posedge clk) begin
        if (L23dmgmt_we)
            hdr_ram[L23dmgmt_writeaddr] <= L23dmgmt_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            hdr_cnt_reg  <= '0;
            mismatch_reg <= 1'b0;
            o_tdata_reg  <= '0;
            o_tlast_reg  <= 1'b0;
            o_tuser_reg  <= 1'b0;
            o_tvalid_reg <= 1'b0;
            dropcnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            hdr_cnt_reg  <= hdr_cnt_next;
            mismatch_reg <= mismatch_next;
            o_tdata_reg  <= o_tdata_next;
            o_tlast_reg  <= o_tlast_next;
            o_tuser_reg  <= o_tuser_next;
            o_tvalid_reg <= o_tvalid_next;
            dropcnt_reg  <= dropcnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hdr_cnt_next  = hdr_cnt_reg;
        mismatch_next = mismatch_reg;
        o_tdata_next  = o_tdata_reg;
        o_tlast_next  = o_tlast_reg;
        o_tuser_next  = o_tuser_reg;
        o_tvalid_next = o_tvalid_reg;
        dropcnt_next  = dropcnt_reg;
        i_tready      = 1'b0;
        drop_inc      = 1'b0;
        after_pkt     = L23dmgmt_run ? HDR : IDLE;
        mis_any       = mismatch_reg |
                        (L23dmgmt_cmpen & (L23i_tdata != hdr_ram[hdr_cnt_reg]));

        // Output register drains independently of the input side.
        if (o_tvalid_reg && L23o_tready)
            o_tvalid_next = 1'b0;

        case (state_reg)
            IDLE: i_tready = 1'b0;
            HDR:  i_tready = 1'b1;
            PASS: i_tready = ~o_tvalid_reg | L23o_tready;
            DROP: i_tready = 1'b1;
            default: i_tready = 1'b0;
        endcase

        accept = L23i_tvalid & i_tready;

        case (state_reg)
            IDLE: begin
                if (L23dmgmt_run) begin
                    state_next    = HDR;
                    hdr_cnt_next  = '0;
                    mismatch_next = 1'b0;
                end
            end
            HDR: begin
                if (accept) begin
                    if (L23i_tlast) begin
                        // Packet ended inside the header: runt.
                        drop_inc      = 1'b1;
                        state_next    = after_pkt;
                        hdr_cnt_next  = '0;
                        mismatch_next = 1'b0;
                    end else if (hdr_cnt_reg == L23dmgmt_refvalue) begin
                        state_next    = mis_any ? DROP : PASS;
                        mismatch_next = mis_any;
                    end else begin
                        hdr_cnt_next  = hdr_cnt_reg + 1'b1;
                        mismatch_next = mis_any;
                    end
                end
            end
            PASS: begin
                if (accept) begin
                    o_tdata_next  = L23i_tdata;
                    o_tlast_next  = L23i_tlast;
                    o_tuser_next  = L23i_tlast & L23i_tuser;
                    o_tvalid_next = 1'b1;
                    if (L23i_tlast) begin
                        state_next    = after_pkt;
                        hdr_cnt_next  = '0;
                        mismatch_next = 1'b0;
                    end
                end
            end
            DROP: begin
                if (accept && L23i_tlast) begin
                    drop_inc      = 1'b1;
                    state_next    = after_pkt;
                    hdr_cnt_next  = '0;
                    mismatch_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        if (drop_inc && (dropcnt_reg != {CNT_W{1'b1}}))
            dropcnt_next = dropcnt_reg + 1'b1;
    end

    assign L23i_tready      = i_tready;
    assign L23o_tdata       = o_tdata_reg;
    assign L23o_tlast       = o_tlast_reg;
    assign L23o_tuser       = o_tuser_reg;
    assign L23o_tvalid      = o_tvalid_reg;
    assign L23dmgmt_dropcnt = dropcnt_reg;
    assign L23dmgmt_idle    = (state_reg == IDLE) & ~o_tvalid_reg;

endmodule
